// File: rtl/return_address_stack_pkg.sv
// Shared types and configuration defaults for the return-address stack.
package return_address_stack_pkg;

  // Core configuration record; the RAS sizing fields seed the block parameters.
  typedef struct packed {
    int unsigned ras_depth;
    int unsigned ras_checkpoints;
  } cpu_config_t;

  localparam cpu_config_t DEFAULT_CONFIG = '{ras_depth: 32'd8, ras_checkpoints: 32'd8};

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned RAS_PTR_W = $clog2(DEFAULT_CONFIG.ras_depth);

  typedef logic [RAS_PTR_W-1:0] ras_ptr_t;
  typedef logic [ADDR_W-1:0]    ras_addr_t;

endpackage

// File: rtl/ras_checkpoint_fifo.sv
// FIFO of stack-pointer snapshots, one per in-flight predicted branch.
module ras_checkpoint_fifo
  import return_address_stack_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [IDX_W-1:0]  head_q, head_d;
  logic [IDX_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_acc;
  logic              push_acc;

  // A pop on an empty FIFO is ignored; a push into a full FIFO is only taken
  // when a pop in the same cycle frees the slot.
  always_comb begin
    mem_d    = mem_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    pop_acc  = pop && (count_q != '0);
    push_acc = push && ((count_q != CNT_W'(DEPTH)) || pop_acc);
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_acc) begin
        mem_d[tail_q] = wr_data;
        tail_d        = tail_q + IDX_W'(1);
      end
      if (pop_acc) begin
        head_d = head_q + IDX_W'(1);
      end
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign rd_data = mem_q[head_q];
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/return_address_stack.sv
// Speculative return-address stack with per-branch pointer checkpoints.
module return_address_stack
  import return_address_stack_pkg::*;
#(
  parameter int unsigned RAS_DEPTH   = DEFAULT_CONFIG.ras_depth,
  parameter int unsigned CHECKPOINTS = DEFAULT_CONFIG.ras_checkpoints
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] new_addr,
  input  logic              branch_fetched,
  input  logic              branch_retired,
  input  logic              branch_flush,
  output logic [ADDR_W-1:0] addr,
  output logic              checkpoint_full
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] stack_q [RAS_DEPTH];
  logic [ADDR_W-1:0] stack_d [RAS_DEPTH];
  logic [PTR_W-1:0]  tos_q, tos_d;

  logic             ckpt_push;
  logic             ckpt_pop;
  logic [PTR_W-1:0] ckpt_head;
  logic             ckpt_full;
  logic             ckpt_empty;

  // Next stack state; flush wins and only restores the pointer, never contents.
  always_comb begin
    stack_d = stack_q;
    tos_d   = tos_q;
    if (branch_flush) begin
      if (!ckpt_empty) begin
        tos_d = ckpt_head;
      end
    end else if (push && pop) begin
      stack_d[tos_q] = new_addr;
    end else if (push) begin
      tos_d          = tos_q + PTR_W'(1);
      stack_d[tos_d] = new_addr;
    end else if (pop) begin
      tos_d = tos_q - PTR_W'(1);
    end
  end

  // Stack entries and top-of-stack pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_q <= '{default: '0};
      tos_q   <= '0;
    end else begin
      stack_q <= stack_d;
      tos_q   <= tos_d;
    end
  end

  assign ckpt_push = branch_fetched && !branch_flush;
  assign ckpt_pop  = branch_retired && !branch_flush;

  // Snapshots record the pointer as it will be after this cycle's push/pop.
  ras_checkpoint_fifo #(
    .DEPTH  (CHECKPOINTS),
    .DATA_W (PTR_W)
  ) u_ckpt_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (ckpt_push),
    .pop     (ckpt_pop),
    .clear   (branch_flush),
    .wr_data (tos_d),
    .rd_data (ckpt_head),
    .full    (ckpt_full),
    .empty   (ckpt_empty)
  );

  assign addr            = stack_q[tos_q];
  assign checkpoint_full = ckpt_full;

  // Fetch must not over-allocate checkpoints or retire branches it never fetched.
  always_ff @(posedge clk) begin
    if (rst_n && !branch_flush) begin
      assert (!(branch_retired && ckpt_empty))
        else $error("branch_retired with no outstanding checkpoint");
      assert (!(branch_fetched && ckpt_full && !branch_retired))
        else $error("branch_fetched while checkpoint FIFO is full");
    end
  end

endmodule

// File: tb/tb_return_address_stack.sv
// Scoreboard bench: directed test-plan sequences plus randomized traffic vs a queue model.
module tb_return_address_stack;

  localparam int D  = 8;
  localparam int CP = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [31:0] new_addr = '0;
  logic        branch_fetched = 1'b0;
  logic        branch_retired = 1'b0;
  logic        branch_flush = 1'b0;
  logic [31:0] addr;
  logic        checkpoint_full;

  return_address_stack #(
    .RAS_DEPTH   (D),
    .CHECKPOINTS (CP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .push            (push),
    .pop             (pop),
    .new_addr        (new_addr),
    .branch_fetched  (branch_fetched),
    .branch_retired  (branch_retired),
    .branch_flush    (branch_flush),
    .addr            (addr),
    .checkpoint_full (checkpoint_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        full;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model: plain array stack, integer pointer, queue of snapshots.
  logic [31:0] m_stk[D];
  int          m_tos;
  int          m_cq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_stk[i] = '0;
    m_tos = 0;
    m_cq.delete();
  endtask

  task automatic model_step(input logic p, input logic po, input logic [31:0] a,
                            input logic f, input logic r, input logic fl);
    if (fl) begin
      if (m_cq.size() > 0) m_tos = m_cq[0];
      m_cq.delete();
    end else begin
      if (p && po) m_stk[m_tos] = a;
      else if (p) begin
        m_tos = (m_tos + 1) % D;
        m_stk[m_tos] = a;
      end else if (po) m_tos = (m_tos + D - 1) % D;
      if (r && m_cq.size() > 0) void'(m_cq.pop_front());
      if (f && m_cq.size() < CP) m_cq.push_back(m_tos);
    end
  endtask

  // Drive one cycle of stimulus and queue the response expected after the edge.
  task automatic drive(input logic p, input logic po, input logic [31:0] a,
                       input logic f, input logic r, input logic fl);
    exp_t e;
    @(negedge clk);
    push = p; pop = po; new_addr = a;
    branch_fetched = f; branch_retired = r; branch_flush = fl;
    model_step(p, po, a, f, r, fl);
    e.addr = m_stk[m_tos];
    e.full = (m_cq.size() == CP);
    sb_q.push_back(e);
  endtask

  // Spot check against literal values from the test plan, after the next edge.
  task automatic spot(input string nm, input logic [31:0] ea, input logic ef);
    @(posedge clk);
    #2;
    check({nm, "_addr"}, addr, ea);
    check({nm, "_full"}, {31'd0, checkpoint_full}, {31'd0, ef});
  endtask

  task automatic do_reset();
    @(negedge clk);
    push = 0; pop = 0; new_addr = '0;
    branch_fetched = 0; branch_retired = 0; branch_flush = 0;
    rst_n = 1'b0;
    #1;
    check("reset_addr", addr, 32'h0);
    check("reset_full", {31'd0, checkpoint_full}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare every post-edge output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_addr", addr, e.addr);
        check("sb_full", {31'd0, checkpoint_full}, {31'd0, e.full});
      end
    end
  end

  initial begin
    logic p, po, f, r, fl;
    model_reset();
    repeat (2) @(negedge clk);
    check("init_addr", addr, 32'h0);
    check("init_full", {31'd0, checkpoint_full}, 32'h0);
    rst_n = 1'b1;

    // Basic push/pop.
    drive(1, 0, 32'h1000, 0, 0, 0); spot("push1", 32'h1000, 0);
    drive(1, 0, 32'h2000, 0, 0, 0); spot("push2", 32'h2000, 0);
    drive(0, 1, 32'h0,    0, 0, 0); spot("pop1",  32'h1000, 0);

    // Overflow wraps over the oldest entry.
    do_reset();
    for (int k = 1; k <= 9; k++) drive(1, 0, 32'h100 * k, 0, 0, 0);
    spot("ovf_push", 32'h900, 0);
    for (int k = 0; k < 8; k++) drive(0, 1, 32'h0, 0, 0, 0);
    spot("ovf_pop", 32'h900, 0);

    // Simultaneous push+pop replaces TOS.
    do_reset();
    drive(1, 0, 32'h500,  0, 0, 0);
    drive(1, 0, 32'h1000, 0, 0, 0);
    drive(1, 1, 32'h3000, 0, 0, 0); spot("replace", 32'h3000, 0);
    drive(0, 1, 32'h0,    0, 0, 0); spot("replace_pop", 32'h500, 0);

    // Checkpoint and flush restore.
    do_reset();
    drive(1, 0, 32'hA0, 1, 0, 0);
    drive(1, 0, 32'hB0, 0, 0, 0);
    drive(1, 0, 32'hC0, 0, 0, 0); spot("pre_flush", 32'hC0, 0);
    drive(0, 0, 32'h0,  0, 0, 1); spot("flush", 32'hA0, 0);

    // Fill, overlap fetch+retire while full, then retire.
    for (int k = 0; k < CP; k++) drive(0, 0, 32'h0, 1, 0, 0);
    spot("full", 32'hA0, 1);
    drive(0, 0, 32'h0, 1, 1, 0); spot("full_fr", 32'hA0, 1);
    drive(0, 0, 32'h0, 0, 1, 0); spot("retire", 32'hA0, 0);

    // Flush has priority over a same-cycle push.
    drive(0, 0, 32'h0,  0, 0, 1); spot("flush2", 32'hA0, 0);
    drive(1, 0, 32'hDD, 0, 0, 1); spot("flush_prio", 32'hA0, 0);

    // Randomized legal traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      p  = ($urandom_range(0, 9) < 4);
      po = ($urandom_range(0, 9) < 4);
      r  = (m_cq.size() > 0) && ($urandom_range(0, 3) == 0);
      f  = ((m_cq.size() < CP) || r) && ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 39) == 0);
      drive(p, po, $urandom, f, r, fl);
    end
    drive(0, 0, 32'h0, 0, 0, 0);

    for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/return_address_stack.md
# return_address_stack

Speculative return-address stack (RAS) that serves the fetch-side return prediction path and the branch predictor's retire indication. Calls predicted at fetch push their return address, and predicted returns pop it. The current top of stack is driven back to fetch as the return target. Each predicted control-flow instruction checkpoints the stack pointer so that a branch flush can restore it; the checkpoint is released when the branch predictor reports the branch retired.

## Interface
Parameters:
- RAS_DEPTH, 8, number of stack entries; power of two, ≥2
- CHECKPOINTS, 8, maximum in-flight predicted branches; power of two, ≥2

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- push  in  1  predicted call at fetch; push new_addr
- pop  in  1  predicted return at fetch; pop TOS
- new_addr  in  32  return address (call PC + 4) for push
- branch_fetched  in  1  predicted control-flow instruction accepted by fetch; allocate checkpoint
- branch_retired  in  1  oldest outstanding predicted branch resolved; release oldest checkpoint
- branch_flush  in  1  misprediction; restore pointer, clear checkpoints
- addr  out  32  current top-of-stack entry (return prediction)
- checkpoint_full  out  1  checkpoint FIFO holds CHECKPOINTS entries; fetch must not assert branch_fetched

## Operation
- State: stack[RAS_DEPTH] of 32-bit entries, tos pointer of log2(RAS_DEPTH) bits, and checkpoint FIFO of tos snapshots with count of 0..CHECKPOINTS.
- addr = stack[tos], combinational from registers.
- push only: tos ← tos+1 (mod RAS_DEPTH); stack[tos+1] ← new_addr. On overflow, the wrap overwrites the oldest entry silently.
- pop only: tos ← tos−1 (mod RAS_DEPTH); the entry is not cleared. Pop when logically empty still wraps; no empty detection.
- push and pop together: stack[tos] ← new_addr; tos unchanged (replace TOS).
- branch_fetched: enqueue the post-update tos, i.e. the value tos takes at the next edge, including a same-cycle push/pop.
- branch_retired: dequeue the oldest checkpoint.
  - fetched and retired together with count>0: count unchanged; head advances and tail writes.
  - retired with count=0: ignored; assertion fires.
- branch_fetched with count=CHECKPOINTS and no retire: dropped; assertion fires.
- branch_flush has highest priority:
  - tos ← oldest checkpoint if count>0, else unchanged.
  - FIFO cleared (count←0, head=tail).
  - push/pop/branch_fetched/branch_retired in the same cycle are ignored.
  - Stack contents are not restored (accepted prediction inaccuracy).
- checkpoint_full = (count == CHECKPOINTS).

## Timing
- Reset (async assert, sync release): tos=0; all stack entries 0; count=0; head=tail=0; addr=0; checkpoint_full=0.
- push/pop in cycle N → addr reflects the new TOS in N+1. No bypass of new_addr to addr in N.
- branch_fetched in N → count and checkpoint_full update in N+1. A retire in N+1 may release that checkpoint.
- branch_flush in N → restored tos visible on addr in N+1; checkpoint_full=0 in N+1.
- Pointer and FIFO index arithmetic is unsigned modulo depth. Count is log2(CHECKPOINTS)+1 bits.
- Reset mid-operation returns all state to reset values immediately; no pending operation survives.

## Structure
- Sub-module ras_checkpoint_fifo: a CHECKPOINTS-deep FIFO of log2(RAS_DEPTH)-bit entries with push, pop, clear, head data and full/empty outputs, on the same clk/rst_n.
- The shared package (cva5_types) holds ras_ptr_t, typed from RAS_DEPTH.
- Defaults for RAS_DEPTH/CHECKPOINTS come from cpu_config_t in cva5_config, so the instantiation passes CONFIG fields.

## Test plan
- Reset check: after rst_n release, addr=0 and checkpoint_full=0. Then push 0x1000, push 0x2000 → addr 0x2000, then pop → addr 0x1000 one cycle after each op.
- Overflow: 9 pushes of 0x100·k (k=1..9) with RAS_DEPTH=8 → addr=0x900; 8 pops → addr=0x900 again (entry 1 overwritten by wrap).
- Simultaneous push+pop: TOS=0x1000, push+pop with new_addr=0x3000 → addr=0x3000; tos unchanged, so a following pop yields the prior lower entry.
- Checkpoint flush:
  - push 0xA0 with branch_fetched (checkpoint tos=1);
  - push 0xB0 and push 0xC0 without branch_fetched;
  - branch_flush → addr=0xA0 next cycle and checkpoint_full=0.
- Full/retire:
  - 8 branch_fetched → checkpoint_full=1;
  - fetched+retired together → checkpoint_full stays 1;
  - retired alone → checkpoint_full=0 next cycle.
- Flush priority: branch_flush with push 0xDD in the same cycle, count=0 → tos and addr unchanged; the push is ignored.
